i2c_target_regs: RTL
====================

Name: i2c_target_regs

Overview:
- I2C target (slave) responder, the far end of the team's I2C initiator microsequencer; answers a fixed 7-bit device address and maps I2C transfers onto a simple 8-bit register bus.
- Used as the on-chip codec register model in benches.
- Also used as a control port that lets an external I2C master reach fabric registers.
- Standard-mode/fast-mode timing; the system clock is ≥16x SCL.

Parameters:
- DEV_ADDR, 7'h3B, 7-bit target address matched after START.
- SYNC_STAGES, 2, synchroniser depth on SCL/SDA inputs (≥2).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  reset, asynchronous assert, active-low; deassertion synchronised externally.
- i2c_scl_i  in  1  SCL from pad.
- i2c_sda_i  in  1  SDA from pad.
- i2c_sda_o  out  1  constant 0 (open-drain data).
- i2c_sda_t  out  1  pad tristate: 0 = drive low, 1 = release.
- reg_addr  out  8  register pointer.
- reg_wdata  out  8  write data.
- reg_we  out  1  one-cycle write strobe.
- reg_re  out  1  one-cycle read strobe.
- reg_rdata  in  8  read data, valid exactly 1 clk after reg_re.
- busy  out  1  high from address match until STOP/START.
- start_det  out  1  one-cycle pulse per START or repeated START.
- stop_det  out  1  one-cycle pulse per STOP.

Behaviour:
- Reset values: i2c_sda_o=0, i2c_sda_t=1, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, busy=0, start_det=0, stop_det=0, state=IDLE. Synchronisers reset to 1.
- Edge detection on synchronised signals, one extra delay register each:
  - SCL rise/fall.
  - START = SDA fall while SCL high.
  - STOP = SDA rise while SCL high.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- Bit counter: 3 bits. Data is shifted MSB first, sampled on SCL rise. SDA is only changed on the clk after an SCL-fall detect.
- START from any state:
  - Goes to ADDR, bit counter = 7, i2c_sda_t=1.
  - The reg_addr pointer is preserved, which supports repeated-start reads.
- STOP from any state: goes to IDLE, i2c_sda_t=1, busy=0.
- ADDR: after 8 bits, compare [7:1] with DEV_ADDR.
  - Match: on the next SCL fall, drive ACK (sda_t=0), busy=1, enter ADDR_ACK.
  - Mismatch: go to IGNORE and never drive SDA.
- ADDR_ACK:
  - Write (R/W=0): on the SCL fall ending ACK, release SDA and go to PTR.
  - Read (R/W=1): pulse reg_re on the SCL fall that starts ACK; load reg_rdata into the shift register the following clk. On the SCL fall ending ACK, drive bit 7 and go to RDATA.
- PTR: after 8 bits, reg_addr <= byte. ACK and go to WDATA.
- WDATA: after 8 bits, on the SCL fall starting ACK:
  - reg_wdata <= byte and reg_we=1 for one clk.
  - reg_addr increments on the following clk (8-bit wrap FF→00).
  - Drive ACK, then return to WDATA.
- RDATA: drive the shift-register MSB on each SCL fall. After 8 bits, release SDA for the master ACK and go to RDATA_ACK.
- RDATA_ACK: sample SDA on SCL rise.
  - ACK (0): reg_addr+1 (wrap), pulse reg_re, load the byte, drive the first bit on the next SCL fall, go to RDATA.
  - NACK: go to IGNORE, SDA released until STOP/START.
- Fixed rules:
  - Target never stretches SCL.
  - No ACK is ever driven in IGNORE.
  - If START and STOP are both detected in the same clk, START has priority (cannot occur legally; defined for X-safety).
- Reset mid-transfer: sda_t releases immediately (async); the bus is then ignored until the next START.

Decomposition:
- Package i2c_pkg: state encoding constants, and ACK=1'b0 / NACK=1'b1.
- One sub-module, i2c_line_sync: synchroniser plus edge/START/STOP detect for both lines, parameterised by SYNC_STAGES.

Test Plan:
- Write pointer: START, 0x76, 0x40, 0x5A, STOP → ACK on all 3 bytes; reg_we one pulse with reg_addr=0x40, reg_wdata=0x5A; afterwards reg_addr=0x41; stop_det pulse.
- Burst write at wrap: pointer 0xFF, data 0x11, 0x22 → writes FF=0x11 and 00=0x22; final reg_addr=0x01.
- Repeated-start read: write pointer 0x10, Sr, 0x77, model returns 0xA5, 0x3C, master ACKs then NACKs, STOP → SDA bits 10100101 then 00111100; reg_re at addresses 0x10 and 0x11; SDA released after NACK.
- Wrong address 0x50 (write byte 0xA0) → i2c_sda_t stays 1 for the whole transfer; no reg_we/reg_re; busy=0.
- Reset asserted mid-RDATA while driving 0 → i2c_sda_t=1 within the same clk; next transaction after START decodes correctly.
- Glitch-free STOP during WDATA bit 4 → IDLE; no reg_we; busy drops.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and acknowledge levels for the I2C target
package i2c_pkg;
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: synchronises SCL/SDA and flags SCL edges plus START/STOP conditions
// Ports: clk, rst_n; scl_pad/sda_pad raw pad inputs; sda synchronised SDA level;
// scl_rise/scl_fall/start/stop single-clk event flags.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_pad,
  input  logic sda_pad,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);
  logic [SYNC_STAGES-1:0] scl_sr, sda_sr;
  logic scl, scl_d, sda_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      scl_sr <= '1;
      sda_sr <= '1;
      scl_d  <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_sr <= {scl_sr[SYNC_STAGES-2:0], scl_pad};
      sda_sr <= {sda_sr[SYNC_STAGES-2:0], sda_pad};
      scl_d  <= scl;
      sda_d  <= sda;
    end
  assign scl      = scl_sr[SYNC_STAGES-1];
  assign sda      = sda_sr[SYNC_STAGES-1];
  assign scl_rise = scl & ~scl_d;
  assign scl_fall = ~scl & scl_d;
  // SCL must be high on both samples so an SDA edge racing an SCL edge is never a START/STOP
  assign start    = scl & scl_d & sda_d & ~sda;
  assign stop     = scl & scl_d & ~sda_d & sda;
endmodule

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target at a fixed address mapping transfers onto an 8-bit register bus
// Ports: clk, rst_n; i2c_scl_i/i2c_sda_i pad inputs; i2c_sda_o/i2c_sda_t open-drain SDA;
// reg_addr/reg_wdata/reg_we/reg_re/reg_rdata register bus; busy/start_det/stop_det status.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h3B,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i2c_scl_i,
  input  logic       i2c_sda_i,
  output logic       i2c_sda_o,
  output logic       i2c_sda_t,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       start_det,
  output logic       stop_det
);
  logic sda, scl_rise, scl_fall, start, stop;
  logic re_d, done, first, rw;
  logic [2:0] bitcnt;
  logic [7:0] shreg;
  state_t state;
  assign i2c_sda_o = 1'b0;
  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_pad  (i2c_scl_i),
    .sda_pad  (i2c_sda_i),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );
  // done marks a completed byte; it is consumed by the SCL fall that opens the ACK slot.
  // first marks a read byte whose MSB still has to be put on the bus after a master ACK.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      i2c_sda_t <= 1'b1;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      re_d      <= 1'b0;
      done      <= 1'b0;
      first     <= 1'b0;
      rw        <= 1'b0;
      bitcnt    <= 3'd7;
      shreg     <= '0;
    end else begin
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      re_d      <= reg_re;
      start_det <= start;
      stop_det  <= stop & ~start;
      if (re_d) shreg <= reg_rdata;
      if (reg_we) reg_addr <= reg_addr + 8'd1;
      if (start) begin
        state     <= ADDR;
        bitcnt    <= 3'd7;
        done      <= 1'b0;
        first     <= 1'b0;
        i2c_sda_t <= 1'b1;
        busy      <= 1'b0;
      end else if (stop) begin
        state     <= IDLE;
        i2c_sda_t <= 1'b1;
        busy      <= 1'b0;
      end else if (scl_rise) begin
        if (state == ADDR || state == PTR || state == WDATA) begin
          shreg  <= {shreg[6:0], sda};
          bitcnt <= bitcnt - 3'd1;
          done   <= bitcnt == 3'd0;
        end else if (state == RDATA_ACK) begin
          if (sda == NACK) state <= IGNORE;
          else begin
            reg_addr <= reg_addr + 8'd1;
            reg_re   <= 1'b1;
            first    <= 1'b1;
            state    <= RDATA;
          end
        end
      end else if (scl_fall) begin
        case (state)
          ADDR: if (done) begin
            done <= 1'b0;
            if (shreg[7:1] == DEV_ADDR) begin
              i2c_sda_t <= ACK;
              busy      <= 1'b1;
              rw        <= shreg[0];
              reg_re    <= shreg[0];
              state     <= ADDR_ACK;
            end else state <= IGNORE;
          end
          ADDR_ACK: if (rw) begin
            i2c_sda_t <= shreg[7];
            shreg     <= {shreg[6:0], 1'b1};
            bitcnt    <= 3'd7;
            state     <= RDATA;
          end else begin
            i2c_sda_t <= 1'b1;
            state     <= PTR;
          end
          PTR: if (done) begin
            done      <= 1'b0;
            reg_addr  <= shreg;
            i2c_sda_t <= ACK;
            state     <= PTR_ACK;
          end
          PTR_ACK, WDATA_ACK: begin
            i2c_sda_t <= 1'b1;
            state     <= WDATA;
          end
          WDATA: if (done) begin
            done      <= 1'b0;
            reg_wdata <= shreg;
            reg_we    <= 1'b1;
            i2c_sda_t <= ACK;
            state     <= WDATA_ACK;
          end
          RDATA: if (first) begin
            first     <= 1'b0;
            i2c_sda_t <= shreg[7];
            shreg     <= {shreg[6:0], 1'b1};
            bitcnt    <= 3'd7;
          end else if (bitcnt == 3'd0) begin
            i2c_sda_t <= 1'b1;
            state     <= RDATA_ACK;
          end else begin
            i2c_sda_t <= shreg[7];
            shreg     <= {shreg[6:0], 1'b1};
            bitcnt    <= bitcnt - 3'd1;
          end
          default: ;
        endcase
      end
    end
endmodule
